// File: rtl/risc32_pkg.sv
// risc32_pkg: opcodes, instruction classes and pipeline latch types shared by the risc32 core
package risc32_pkg;

    localparam int XW = 32;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b100001;
    localparam logic [5:0] OP_SUBI  = 6'b100010;
    localparam logic [5:0] OP_SLTI  = 6'b100011;
    localparam logic [5:0] OP_LW    = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b100101;
    localparam logic [5:0] OP_BEQZ  = 6'b100110;
    localparam logic [5:0] OP_BNEQZ = 6'b100111;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} iclass_e;

    typedef struct packed {
        logic          valid;
        logic [XW-1:0] pc;
        logic [XW-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic          valid;
        iclass_e       cls;
        logic [5:0]    op;
        logic [4:0]    rd;
        logic [XW-1:0] a;
        logic [XW-1:0] b;
        logic [XW-1:0] sd;
        logic [XW-1:0] pc;
    } id_ex_t;

    typedef struct packed {
        logic          valid;
        iclass_e       cls;
        logic [4:0]    rd;
        logic [XW-1:0] res;
        logic [XW-1:0] sd;
    } ex_mem_t;

    typedef struct packed {
        logic          valid;
        iclass_e       cls;
        logic [4:0]    rd;
        logic [XW-1:0] data;
    } mem_wb_t;

    function automatic iclass_e op_class(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
            OP_LW:                                         return LOAD;
            OP_SW:                                         return STORE;
            OP_BEQZ, OP_BNEQZ:                             return BRANCH;
            OP_HLT:                                        return HALT;
            default:                                       return NOP;
        endcase
    endfunction

    function automatic logic writes_rf(input iclass_e c);
        return c inside {RR_ALU, RM_ALU, LOAD};
    endfunction

endpackage

// File: rtl/risc32_alu.sv
// risc32_alu: combinational ALU; loads, stores and unknown opcodes fall through to add
module risc32_alu
    import risc32_pkg::*;
(
    input  logic [5:0]    op_i,
    input  logic [XW-1:0] a_i,
    input  logic [XW-1:0] b_i,
    output logic [XW-1:0] res_o
);

    // Select the operation; the add default also forms load/store effective addresses
    always_comb begin
        case (op_i)
            OP_SUB, OP_SUBI: res_o = a_i - b_i;
            OP_AND:          res_o = a_i & b_i;
            OP_OR:           res_o = a_i | b_i;
            OP_SLT, OP_SLTI: res_o = {{(XW-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_MUL:          res_o = a_i * b_i;
            default:         res_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/risc32_pipe_cpu.sv
// risc32_pipe_cpu: five-stage in-order core, unified memory, no forwarding or interlocks
module risc32_pipe_cpu
    import risc32_pkg::*;
#(
    parameter int XLEN      = XW,
    parameter int MEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic halted
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [XLEN-1:0] mem [MEM_DEPTH];
    logic [XLEN-1:0] regb [32];
    logic [AW-1:0]   pc, pc_d;

    if_id_t  if_id_q, if_id_d;
    id_ex_t  id_ex_q, id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [5:0]      id_op;
    logic [4:0]      id_rd, id_rs, id_rt;
    iclass_e         id_cls;
    logic [XLEN-1:0] id_imm, rs_val, rt_val, rd_val, alu_res;
    logic [AW-1:0]   br_tgt, mem_addr;
    logic            wb_we, mem_we, br_taken, fetch_stop;

    assign id_op  = if_id_q.instr[31:26];
    assign id_rd  = if_id_q.instr[25:21];
    assign id_rs  = if_id_q.instr[20:16];
    assign id_rt  = if_id_q.instr[15:11];
    assign id_imm = {{(XLEN-16){if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    assign id_cls = op_class(id_op);

    // Write-first register file: ID sees the value WB is writing this cycle
    assign wb_we  = mem_wb_q.valid && writes_rf(mem_wb_q.cls) && mem_wb_q.rd != 5'd0 && !halted;
    assign rs_val = (id_rs == 5'd0) ? '0 : (wb_we && mem_wb_q.rd == id_rs) ? mem_wb_q.data : regb[id_rs];
    assign rt_val = (id_rt == 5'd0) ? '0 : (wb_we && mem_wb_q.rd == id_rt) ? mem_wb_q.data : regb[id_rt];
    assign rd_val = (id_rd == 5'd0) ? '0 : (wb_we && mem_wb_q.rd == id_rd) ? mem_wb_q.data : regb[id_rd];

    risc32_alu u_alu (
        .op_i (id_ex_q.op),
        .a_i  (id_ex_q.a),
        .b_i  (id_ex_q.b),
        .res_o(alu_res)
    );

    assign br_taken = id_ex_q.valid && id_ex_q.cls == BRANCH && ((id_ex_q.op == OP_BEQZ) == (id_ex_q.a == '0));
    assign br_tgt   = AW'(id_ex_q.pc + 1 + id_ex_q.b);

    // Any HLT past IF keeps fetch frozen until reset; a taken branch still flushes one sitting in ID
    assign fetch_stop = halted || (if_id_q.valid && id_cls == HALT) || (id_ex_q.valid && id_ex_q.cls == HALT)
                      || (ex_mem_q.valid && ex_mem_q.cls == HALT) || (mem_wb_q.valid && mem_wb_q.cls == HALT);

    assign mem_addr = ex_mem_q.res[AW-1:0];
    assign mem_we   = ex_mem_q.valid && ex_mem_q.cls == STORE && !halted;

    // IF: redirect on a taken branch, otherwise step or hold while a HLT is in flight
    always_comb begin
        pc_d    = br_taken ? br_tgt : fetch_stop ? pc : pc + 1'b1;
        if_id_d = '{valid: !(br_taken || fetch_stop), pc: XW'(pc), instr: mem[pc]};
    end

    // ID: register read and operand select; the instruction in ID is squashed by a taken branch
    always_comb begin
        id_ex_d = '{valid: if_id_q.valid && !br_taken, cls: id_cls, op: id_op, rd: id_rd,
                    a: rs_val, b: (id_cls == RR_ALU) ? rt_val : id_imm, sd: rd_val, pc: if_id_q.pc};
    end

    // EX: ALU result doubles as the memory address for loads and stores
    always_comb begin
        ex_mem_d = '{valid: id_ex_q.valid, cls: id_ex_q.cls, rd: id_ex_q.rd, res: alu_res, sd: id_ex_q.sd};
    end

    // MEM: loads replace the ALU result with the memory word
    always_comb begin
        mem_wb_d = '{valid: ex_mem_q.valid, cls: ex_mem_q.cls, rd: ex_mem_q.rd,
                     data: (ex_mem_q.cls == LOAD) ? mem[mem_addr] : ex_mem_q.res};
    end

    // Pipeline latches, pc and halt flag; reset drops every in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            halted   <= 1'b0;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc       <= pc_d;
            halted   <= halted || (mem_wb_q.valid && mem_wb_q.cls == HALT);
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // Store port of the unified memory; left unreset so contents can be preloaded
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= ex_mem_q.sd;
    end

    // Register file write port; left unreset so contents can be preloaded
    always_ff @(posedge clk) begin
        if (wb_we) regb[mem_wb_q.rd] <= mem_wb_q.data;
    end

endmodule

// File: tb/tb_risc32_pipe_cpu.sv
// tb_risc32_pipe_cpu: directed programs plus random NOP-padded programs against an ISA-level model
module tb_risc32_pipe_cpu;

    localparam logic [31:0] FILL = 32'h0ce77800;
    localparam logic [31:0] HLT  = 32'hfc000000;
    localparam logic [31:0] PAD  = 32'h40000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic halted;

    logic [31:0] img [1024];
    logic [31:0] rinit [32];
    logic [31:0] mr [32];
    logic [31:0] mm [1024];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    risc32_pipe_cpu dut (.clk(clk), .rst_n(rst_n), .halted(halted));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
        for (int i = 0; i < 32; i++) rinit[i] = 32'(i);
    endtask

    task automatic start();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.mem[i] = img[i];
        for (int i = 0; i < 32; i++) dut.regb[i] = rinit[i];
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    // Sequential instruction-set interpreter; valid only for hazard-free programs
    task automatic model_run(output int hlt_pc);
        logic [31:0] pc, nxt, ins, a, b, imm, res;
        logic [4:0] rd;
        logic wr;
        hlt_pc = -1;
        pc = 0;
        for (int i = 0; i < 32; i++) mr[i] = (i == 0) ? 32'h0 : rinit[i];
        for (int i = 0; i < 1024; i++) mm[i] = img[i];
        for (int s = 0; s < 4000 && hlt_pc < 0; s++) begin
            ins = mm[pc];
            rd  = ins[25:21];
            a   = mr[ins[20:16]];
            b   = mr[ins[15:11]];
            imm = {{16{ins[15]}}, ins[15:0]};
            nxt = (pc + 32'd1) & 32'd1023;
            res = 0;
            wr  = 1'b1;
            case (ins[31:26])
                6'h00: res = a + b;
                6'h01: res = a - b;
                6'h02: res = a & b;
                6'h03: res = a | b;
                6'h04: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h05: res = a * b;
                6'h21: res = a + imm;
                6'h22: res = a - imm;
                6'h23: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                6'h24: res = mm[(a + imm) & 32'd1023];
                6'h25: begin mm[(a + imm) & 32'd1023] = mr[rd]; wr = 1'b0; end
                6'h26: begin wr = 1'b0; if (a == 0) nxt = (pc + 32'd1 + imm) & 32'd1023; end
                6'h27: begin wr = 1'b0; if (a != 0) nxt = (pc + 32'd1 + imm) & 32'd1023; end
                6'h3f: begin wr = 1'b0; hlt_pc = int'(pc); end
                default: wr = 1'b0;
            endcase
            if (wr && rd != 0) mr[rd] = res;
            pc = nxt;
        end
    endtask

    // Random program: each instruction followed by two pads so no hazards exist; forward branches only
    task automatic gen_prog(input int n);
        clear_img();
        for (int i = 0; i < 32; i++) rinit[i] = $urandom;
        for (int i = 512; i < 544; i++) img[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            int p = 3 * i;
            int kind = $urandom_range(0, 9);
            int mx = 3 * n - p - 1;
            logic [5:0] op = 6'($urandom_range(0, 5));
            logic [4:0] rd = 5'($urandom);
            logic [4:0] rs = 5'($urandom);
            logic [15:0] imm = 16'($urandom);
            if (kind == 3 || kind == 4) op = 6'(33 + $urandom_range(0, 2));
            if (kind == 5 || kind == 6) begin
                op = (kind == 5) ? 6'h24 : 6'h25;
                rs = 5'd0;
                imm = 16'(512 + $urandom_range(0, 31));
            end
            if (kind == 7) begin
                op = 6'(38 + $urandom_range(0, 1));
                rs = 5'($urandom_range(0, 2));
                imm = 16'($urandom_range(0, (mx < 8) ? mx : 8));
            end
            if (kind == 8) op = 6'b010101;
            img[p] = {op, rd, rs, imm};
            img[p + 1] = PAD;
            img[p + 2] = PAD;
        end
        img[3 * n] = HLT;
    endtask

    initial begin
        logic [31:0] s_exp, s_got;
        int hp;

        // Reference program with padding between dependents
        clear_img();
        img[0] = 32'h84200005; img[1] = 32'h8440000f; img[2] = 32'h84600014;
        img[3] = FILL; img[4] = FILL; img[5] = 32'h00811000; img[6] = FILL; img[7] = FILL;
        img[8] = 32'h04a30800; img[9] = FILL; img[10] = FILL; img[11] = HLT;
        start();
        check("reset_pc", 32'(dut.pc), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        wait_halt("prog1_halt20", 20);
        check("prog1_r0", dut.regb[0], 32'd0);
        check("prog1_r1", dut.regb[1], 32'd5);
        check("prog1_r2", dut.regb[2], 32'd15);
        check("prog1_r3", dut.regb[3], 32'd20);
        check("prog1_r4", dut.regb[4], 32'd20);
        check("prog1_r5", dut.regb[5], 32'd15);
        check("prog1_r7", dut.regb[7], 32'd15);

        // Back-to-back dependent reads stale value; r0 write discarded; freeze after halt
        clear_img();
        img[0] = 32'h84200005; img[1] = 32'h00811000; img[2] = 32'h84000007;
        img[3] = FILL; img[4] = FILL; img[5] = 32'h85800003; img[6] = HLT;
        start();
        wait_halt("stale_halt", 40);
        check("stale_r1", dut.regb[1], 32'd5);
        check("stale_r4", dut.regb[4], 32'd3);
        check("r0_write", dut.regb[0], 32'd0);
        check("r0_read", dut.regb[12], 32'd3);
        check("halt_pc", 32'(dut.pc), 32'd7);
        repeat (10) @(negedge clk);
        s_exp = 0;
        s_got = 0;
        for (int i = 0; i < 1024; i++) begin
            s_exp += img[i] ^ 32'(i);
            s_got += dut.mem[i] ^ 32'(i);
        end
        check("freeze_pc", 32'(dut.pc), 32'd7);
        check("freeze_mem", s_got, s_exp);
        check("freeze_halted", 32'(halted), 32'd1);

        // Taken branch squashes the two younger instructions
        clear_img();
        rinit[1] = 32'd0;
        img[0] = 32'h98010002; img[1] = 32'h84c00001; img[2] = 32'h84c00002;
        img[3] = 32'h85000009; img[4] = HLT;
        start();
        wait_halt("br_halt", 40);
        check("br_r6", dut.regb[6], 32'd6);
        check("br_r8", dut.regb[8], 32'd9);

        // Store then load through memory
        clear_img();
        rinit[2] = 32'd15;
        img[0] = 32'h94400064; img[1] = FILL; img[2] = FILL; img[3] = 32'h91200064;
        img[4] = FILL; img[5] = FILL; img[6] = HLT;
        start();
        wait_halt("ls_halt", 40);
        check("ls_r9", dut.regb[9], 32'd15);
        check("ls_mem100", dut.mem[100], 32'd15);

        // Reset while ADDI r11 is in EX: no writeback, restart from 0
        clear_img();
        img[0] = 32'h85600055; img[1] = FILL; img[2] = FILL; img[3] = FILL; img[4] = FILL; img[5] = HLT;
        start();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_pc", 32'(dut.pc), 32'd0);
        check("rstmid_halted", 32'(halted), 32'd0);
        repeat (4) @(negedge clk);
        check("rstmid_r11", dut.regb[11], 32'd11);
        rst_n = 1'b1;
        wait_halt("rstmid_halt", 40);
        check("rstmid_rerun_r11", dut.regb[11], 32'h55);

        // Random hazard-free programs against the interpreter
        for (int t = 0; t < 6; t++) begin
            gen_prog(20);
            model_run(hp);
            start();
            wait_halt($sformatf("rand%0d_halt", t), 400);
            for (int r = 1; r < 32; r++) check($sformatf("rand%0d_r%0d", t, r), dut.regb[r], mr[r]);
            for (int a = 512; a < 544; a++) check($sformatf("rand%0d_mem%0d", t, a), dut.mem[a], mm[a]);
            check($sformatf("rand%0d_pc", t), 32'(dut.pc), 32'(hp + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
